// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared types and constants for the tick_gen divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tick_gen_pkg;

  // Output shape of a channel
  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_t;

  // Smallest usable divisor; anything below is raised to this on acceptance
  localparam int DIV_MIN = 2;

endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one divider channel with shadowed divisor/mode applied at period boundaries.
// Latency: q/tick registered, one cycle after the counter value that produces them.
// Backpressure: a new write is only taken while no update is pending (pending exported).
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int W       = 26,
  parameter int DEF_DIV = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         sync,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  input  logic         wr_mode,
  output logic         q,
  output logic         tick,
  output logic         pending
);

  localparam logic [W-1:0] DEF_C = (DEF_DIV < DIV_MIN) ? W'(DIV_MIN) : W'(DEF_DIV);

  logic [W-1:0] cnt;
  logic [W-1:0] div;
  logic [W-1:0] sh_div;
  mode_t        mode;
  mode_t        sh_mode;
  logic         last;
  logic [W-1:0] half;

  // Last count of the period, and the square-wave switch point (odd div favours high)
  assign last = (cnt == div - W'(1));
  assign half = div >> 1;

  // Counter, shadow registers and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      div     <= DEF_C;
      mode    <= MODE_SQUARE;
      sh_div  <= DEF_C;
      sh_mode <= MODE_SQUARE;
      pending <= 1'b0;
      q       <= 1'b0;
      tick    <= 1'b0;
    end else begin
      // A write never lands while an older update is waiting, so set/clear never collide
      if (wr && !pending) begin
        sh_div  <= wr_div;
        sh_mode <= mode_t'(wr_mode);
        pending <= 1'b1;
      end
      if (!en || sync) begin
        // Idle or phase-align: restart from 0 and take any waiting update right away
        cnt  <= '0;
        q    <= 1'b0;
        tick <= 1'b0;
        if (pending) begin
          div     <= sh_div;
          mode    <= sh_mode;
          pending <= 1'b0;
        end
      end else begin
        tick <= last;
        q    <= (mode == MODE_PULSE) ? last : (cnt >= half);
        if (last) begin
          cnt <= '0;
          // Swap only on the wrap so no period is cut short or stretched
          if (pending) begin
            div     <= sh_div;
            mode    <= sh_mode;
            pending <= 1'b0;
          end
        end else begin
          cnt <= cnt + W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// tick_gen: NCH independent programmable clock dividers (square wave or one-cycle pulse).
// Latency: q/tick registered; config applies at the next wrap (running) or next cycle (idle).
// Backpressure: cfg_ready low for the addressed channel while its previous update is pending.
// Build option: define TICK_GEN_SYNC_EN to add the sync_req phase-alignment input.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int W       = 26,
  parameter int DEF_DIV = 50000000
) (
  input  logic                                   clk,
  input  logic                                   reset,
`ifdef TICK_GEN_SYNC_EN
  input  logic                                   sync_req,
`endif
  input  logic [NCH-1:0]                         en,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [W-1:0]                           cfg_div,
  input  logic                                   cfg_mode,
  output logic [NCH-1:0]                         q,
  output logic [NCH-1:0]                         tick
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] pending;
  logic [NCH-1:0] wr;
  logic [W-1:0]   div_clamped;
  logic           sync;

`ifdef TICK_GEN_SYNC_EN
  assign sync = sync_req;
`else
  assign sync = 1'b0;
`endif

  assign div_clamped = (cfg_div < W'(DIV_MIN)) ? W'(DIV_MIN) : cfg_div;

  // Ready mux on the addressed channel; unknown channels always accept and drop the write
  always_comb begin
    cfg_ready = 1'b1;
    wr        = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CW'(i)) begin
        cfg_ready = !reset || !pending[i];
      end
    end
    for (int i = 0; i < NCH; i++) begin
      wr[i] = reset && cfg_valid && cfg_ready && (cfg_ch == CW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_gen_ch #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (div_clamped),
      .wr_mode (cfg_mode),
      .q       (q[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: self-checking bench for tick_gen (NCH=2, W=8, DEF_DIV=10).
// Expected waveforms come from a closed-form phase function per channel.
// Sync scenario is included only when TICK_GEN_SYNC_EN is defined.
module tb_tick_gen;

  localparam int NCH = 2;
  localparam int W   = 8;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [0:0]     cfg_ch;
  logic [W-1:0]   cfg_div;
  logic           cfg_mode;
  logic [NCH-1:0] q;
  logic [NCH-1:0] tick;
`ifdef TICK_GEN_SYNC_EN
  logic           sync_req;
`endif

  tick_gen #(.NCH(NCH), .W(W), .DEF_DIV(10)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef TICK_GEN_SYNC_EN
    .sync_req  (sync_req),
`endif
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .q         (q),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] q;
    logic [1:0] t;
    string      nm;
  } exp_t;

  typedef struct {
    string nm;
    int    ch;
    logic  use_cfg;
    int    div;
    logic  mode;
    int    exp_p;
  } vec_t;

  exp_t sb[$];
  vec_t vec[6];

  int n_cmp = 0;
  int n_bad = 0;

  // Per-channel model: j = edges since enable (-1 = idle), p = period, m = mode
  int   j0, j1, p0, p1;
  logic m0, m1;

  function automatic logic exp_q(input int j, input int p, input logic m);
    if (j < 0) return 1'b0;
    if (m) return ((j % p) == p - 1);
    return ((j % p) >= p / 2);
  endfunction

  function automatic logic exp_t_f(input int j, input int p);
    return (j >= 0) && ((j % p) == p - 1);
  endfunction

  task automatic check(input string nm, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_rdy(input logic exp, input string nm);
    #1;
    check(nm, {1'b0, cfg_ready}, {1'b0, exp});
  endtask

  // One clock: push expectation, take the edge, pop and compare
  task automatic step(input string nm);
    exp_t e;
    e.q  = {exp_q(j1, p1, m1), exp_q(j0, p0, m0)};
    e.t  = {exp_t_f(j1, p1), exp_t_f(j0, p0)};
    e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.nm, "_q"}, q, e.q);
    check({e.nm, "_tick"}, tick, e.t);
    if (j0 >= 0) j0++;
    if (j1 >= 0) j1++;
  endtask

  // Reset with a bogus update presented, which must be ignored
  task automatic do_reset();
    reset     = 1'b0;
    en        = '0;
    cfg_valid = 1'b1;
    cfg_ch    = 1'b0;
    cfg_div   = 8'd3;
    cfg_mode  = 1'b1;
`ifdef TICK_GEN_SYNC_EN
    sync_req  = 1'b0;
`endif
    j0 = -1; j1 = -1;
    p0 = 10; p1 = 10; m0 = 1'b0; m1 = 1'b0;
    chk_rdy(1'b1, "rdy_in_reset");
    step("reset");
    step("reset");
    reset     = 1'b1;
    cfg_valid = 1'b0;
    chk_rdy(1'b1, "rdy_after_reset");
  endtask

  // Write an update to an idle channel; it must be applied on the following cycle
  task automatic cfg_apply(input int ch, input int div, input logic mode);
    cfg_valid = 1'b1;
    cfg_ch    = 1'(ch);
    cfg_div   = 8'(div);
    cfg_mode  = mode;
    chk_rdy(1'b1, "rdy_cfg_idle");
    step("cfg_write");
    cfg_valid = 1'b0;
    chk_rdy(1'b0, "rdy_pending_idle");
    step("cfg_apply");
    chk_rdy(1'b1, "rdy_applied_idle");
  endtask

  task automatic set_vec(input int i, input string nm, input int ch, input logic use_cfg,
                         input int div, input logic mode, input int exp_p);
    vec[i].nm      = nm;
    vec[i].ch      = ch;
    vec[i].use_cfg = use_cfg;
    vec[i].div     = div;
    vec[i].mode    = mode;
    vec[i].exp_p   = exp_p;
  endtask

  initial begin
    set_vec(0, "def10",    0, 1'b0, 0, 1'b0, 10);
    set_vec(1, "sq7",      0, 1'b1, 7, 1'b0, 7);
    set_vec(2, "sq0clamp", 1, 1'b1, 0, 1'b0, 2);
    set_vec(3, "pl1clamp", 0, 1'b1, 1, 1'b1, 2);
    set_vec(4, "pl5",      1, 1'b1, 5, 1'b1, 5);
    set_vec(5, "sq3",      1, 1'b1, 3, 1'b0, 3);

    // Table-driven: one channel at a time from reset, other channel must stay quiet
    for (int v = 0; v < 6; v++) begin
      do_reset();
      if (vec[v].use_cfg) cfg_apply(vec[v].ch, vec[v].div, vec[v].mode);
      if (vec[v].ch == 0) begin
        en = 2'b01; j0 = 0; p0 = vec[v].exp_p; m0 = vec[v].mode;
      end else begin
        en = 2'b10; j1 = 0; p1 = vec[v].exp_p; m1 = vec[v].mode;
      end
      for (int k = 0; k < 2 * vec[v].exp_p + 4; k++) step(vec[v].nm);
      en = '0; j0 = -1; j1 = -1;
      step({vec[v].nm, "_off"});
      step({vec[v].nm, "_off"});
    end

    // Mid-period update on a running channel, other channel configured meanwhile
    do_reset();
    en = 2'b01; j0 = 0;
    for (int k = 0; k < 3; k++) step("upd_run");
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd4; cfg_mode = 1'b0;
    chk_rdy(1'b1, "rdy_upd_ch0");
    step("upd_run");
    cfg_ch = 1'b1; cfg_div = 8'd6; cfg_mode = 1'b1;
    chk_rdy(1'b1, "rdy_upd_ch1");
    step("upd_run");
    cfg_valid = 1'b0; cfg_ch = 1'b0;
    for (int k = 5; k <= 9; k++) begin
      chk_rdy(1'b0, "rdy_ch0_pending");
      step("upd_old_period");
    end
    j0 = 0; p0 = 4;
    chk_rdy(1'b1, "rdy_ch0_applied");
    for (int k = 0; k < 6; k++) step("upd_new_period");
    cfg_ch = 1'b1;
    chk_rdy(1'b1, "rdy_ch1_applied");
    en = 2'b11; j1 = 0; p1 = 6; m1 = 1'b1;
    for (int k = 0; k < 14; k++) step("upd_both");

    // Reset mid-period with an update pending: back to default divisor, update lost
    do_reset();
    en = 2'b01; j0 = 0;
    for (int k = 0; k < 3; k++) step("rst_mid");
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd4; cfg_mode = 1'b1;
    step("rst_mid");
    cfg_valid = 1'b0;
    step("rst_mid");
    step("rst_mid");
    reset = 1'b0;
    chk_rdy(1'b1, "rdy_reset_pending");
    j0 = -1;
    step("rst_mid_edge");
    reset = 1'b1;
    chk_rdy(1'b1, "rdy_reset_cleared");
    j0 = 0;
    for (int k = 0; k < 24; k++) step("rst_mid_after");

    // Enable dropped on the wrap cycle still takes the pending update; restart is a full period
    do_reset();
    en = 2'b01; j0 = 0;
    for (int k = 0; k < 3; k++) step("drop_wrap");
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd4; cfg_mode = 1'b0;
    step("drop_wrap");
    cfg_valid = 1'b0;
    for (int k = 4; k < 9; k++) step("drop_wrap");
    en = 2'b00; j0 = -1;
    step("drop_wrap_edge");
    chk_rdy(1'b1, "rdy_drop_applied");
    en = 2'b01; j0 = 0; p0 = 4;
    for (int k = 0; k < 10; k++) step("drop_reenable");

`ifdef TICK_GEN_SYNC_EN
    // Phase alignment of two offset channels
    do_reset();
    cfg_apply(0, 8, 1'b0);
    cfg_apply(1, 8, 1'b0);
    p0 = 8; p1 = 8;
    en = 2'b10; j1 = 0;
    for (int k = 0; k < 3; k++) step("sync_pre");
    en = 2'b11; j0 = 0;
    for (int k = 0; k < 3; k++) step("sync_pre");
    sync_req = 1'b1; j0 = -1; j1 = -1;
    step("sync_edge");
    sync_req = 1'b0; j0 = 0; j1 = 0;
    for (int k = 0; k < 20; k++) step("sync_post");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
